// File: rtl/reg_file.sv
// Integer register file: 2^ADDR_W x N, one write port, two combinational read
// ports with write-first bypass. Entry 0 is hard-wired to zero.
module reg_file #(
    parameter int N      = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [N-1:0]      wr_data,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [N-1:0]      rs1_data,
    output logic [N-1:0]      rs2_data
);

    localparam int DEPTH = 32'd1 << ADDR_W;

    logic [DEPTH-1:1] wr_sel_s;
    logic [N-1:0]     mem_s [DEPTH];
    logic [N-1:0]     rs1_mux_s;
    logic [N-1:0]     rs2_mux_s;
    logic             rs1_byp_s;
    logic             rs2_byp_s;

    // Write-address decoder; index 0 has no select line, so x0 can never be written.
    always_comb begin
        wr_sel_s = '0;
        for (int i = 1; i < DEPTH; i++) begin
            wr_sel_s[i] = wr_en && (rd_addr == ADDR_W'(i));
        end
    end

    assign mem_s[0] = '0;

    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_entry
        logic [N-1:0] entry_q;
        logic [N-1:0] entry_d;

        // Next value of this entry: load on select, otherwise hold.
        always_comb begin
            entry_d = entry_q;
            if (wr_sel_s[gi]) begin
                entry_d = wr_data;
            end else begin
                entry_d = entry_q;
            end
        end

        // Entry storage; reset takes priority and discards a concurrent write.
        always_ff @(posedge clk) begin
            if (!rst) begin
                entry_q <= '0;
            end else begin
                entry_q <= entry_d;
            end
        end

        assign mem_s[gi] = entry_q;
    end

    // Array read muxes, independent of the bypass path.
    always_comb begin
        rs1_mux_s = mem_s[rs1_addr];
        rs2_mux_s = mem_s[rs2_addr];
    end

    // Bypass hits exclude x0 so a write aimed at x0 never leaks to a reader.
    always_comb begin
        rs1_byp_s = wr_en && (rd_addr == rs1_addr) && (rs1_addr != '0);
        rs2_byp_s = wr_en && (rd_addr == rs2_addr) && (rs2_addr != '0);
    end

    // Read port 1 output: reset forces zero, then x0, then bypass, then array.
    always_comb begin
        rs1_data = '0;
        if (!rst) begin
            rs1_data = '0;
        end else if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (rs1_byp_s) begin
            rs1_data = wr_data;
        end else begin
            rs1_data = rs1_mux_s;
        end
    end

    // Read port 2 output, same priority as port 1.
    always_comb begin
        rs2_data = '0;
        if (!rst) begin
            rs2_data = '0;
        end else if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (rs2_byp_s) begin
            rs2_data = wr_data;
        end else begin
            rs2_data = rs2_mux_s;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: expected read data is queued when inputs are
// driven and compared against the DUT on the following falling edge.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [4:0]  rd_addr;
    logic [31:0] wr_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] model_mem [32];
    int          checks;
    int          errors;

    reg_file #(.N(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_addr  (rd_addr),
        .wr_data  (wr_data),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input logic r, input logic we, input logic [4:0] rd,
                                             input logic [31:0] wd, input logic [4:0] a);
        if (!r)                 return 32'h0000_0000;
        if (a == 5'd0)          return 32'h0000_0000;
        if (we && (rd == a))    return wd;
        return model_mem[a];
    endfunction

    // One cycle: drive inputs, queue expectations, compare at negedge, advance model at posedge.
    task automatic cycle(input logic r, input logic we, input logic [4:0] rd,
                         input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        sb_t e1;
        sb_t e2;
        rst      = r;
        wr_en    = we;
        rd_addr  = rd;
        wr_data  = wd;
        rs1_addr = a1;
        rs2_addr = a2;
        sb_q.push_back('{$sformatf("rs1[%0d]", a1), exp_read(r, we, rd, wd, a1)});
        sb_q.push_back('{$sformatf("rs2[%0d]", a2), exp_read(r, we, rd, wd, a2)});
        @(negedge clk);
        e1 = sb_q.pop_front();
        check_val(e1.tag, rs1_data, e1.val);
        e2 = sb_q.pop_front();
        check_val(e2.tag, rs2_data, e2.val);
        if (!r) begin
            for (int i = 0; i < 32; i++) model_mem[i] = 32'h0000_0000;
        end else if (we && (rd != 5'd0)) begin
            model_mem[rd] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b0;
        wr_en    = 1'b0;
        rd_addr  = 5'd0;
        wr_data  = 32'h0000_0000;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        for (int i = 0; i < 32; i++) model_mem[i] = 32'h0000_0000;
        @(posedge clk);
        #1;

        // Reset held two cycles with a live write and bypassing addresses.
        cycle(1'b0, 1'b1, 5'd9, 32'hCAFE_F00D, 5'd9, 5'd1);
        cycle(1'b0, 1'b1, 5'd9, 32'hCAFE_F00D, 5'd9, 5'd9);
        for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

        // Basic write/read and neighbours.
        cycle(1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd4, 5'd6);
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd4, 5'd6);

        // x0 is immutable and never bypassed.
        cycle(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5);

        // Same-cycle bypass.
        cycle(1'b1, 1'b1, 5'd7, 32'h1111_1111, 5'd1, 5'd2);
        cycle(1'b1, 1'b1, 5'd8, 32'h0808_0808, 5'd7, 5'd7);
        cycle(1'b1, 1'b1, 5'd7, 32'h2222_2222, 5'd7, 5'd8);
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);

        // Reset mid-write discards the write and forces reads to zero.
        cycle(1'b1, 1'b1, 5'd3, 32'h1234_5678, 5'd3, 5'd0);
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7);
        cycle(1'b0, 1'b1, 5'd3, 32'hAAAA_AAAA, 5'd3, 5'd3);
        cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7);

        // Full sweep: fill every entry, then read mirrored pairs.
        for (int i = 1; i < 32; i++)
            cycle(1'b1, 1'b1, 5'(i), 32'h0101_0101 * 32'(i), 5'(i), 5'($urandom_range(0, 31)));
        for (int i = 0; i < 32; i++) cycle(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

        // Random traffic, including occasional resets.
        for (int k = 0; k < 300; k++)
            cycle(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  $urandom(), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Integer register file for the pipelined RV32 core: 2^ADDR_W entries of N bits.
- One synchronous write port is driven by the write-back stage. Two read ports serve the decode stage.
- Entry 0 is hard-wired to zero.
- Internal write-to-read bypass: a value written in cycle t is visible to decode in the same cycle t, so the WB→ID hazard needs no external forwarding.

Parameters:
- N, 32, data width of each register.
- ADDR_W, 5, address width; entry count = 2^ADDR_W (32 entries by default).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-low (rst==0 at a rising clk edge resets).
- wr_en  input  1  write enable from write-back stage.
- rd_addr  input  ADDR_W  destination register index.
- wr_data  input  N  data to write.
- rs1_addr  input  ADDR_W  read port 1 index.
- rs2_addr  input  ADDR_W  read port 2 index.
- rs1_data  output  N  read port 1 data (combinational).
- rs2_data  output  N  read port 2 data (combinational).

Behaviour:
- Storage: 2^ADDR_W entries of N bits. Entry 0 is never written and always reads 0.
- Reset:
  - Every rising edge with rst==0 clears all entries to 0; wr_en is ignored on that edge.
  - While rst==0, rs1_data and rs2_data are forced to 0 regardless of address or bypass.
  - Reset asserted mid-operation discards any write presented on that edge.
- Write:
  - On a rising edge with rst==1, wr_en==1 and rd_addr!=0: entry[rd_addr] <= wr_data.
  - If wr_en==1 and rd_addr==0, no state changes.
- Read (per port p in {rs1, rs2}, combinational, zero latency):
  - If rst==0: 0.
  - Else if p_addr==0: 0.
  - Else if wr_en==1 and rd_addr==p_addr: wr_data (bypass, write-first).
  - Else: entry[p_addr].
- Both ports may address the same entry, including the entry being written; both then return identical data.
- No X propagation: every entry is defined after the first reset edge.
- Outputs before the first reset edge are undefined; the bench applies reset for ≥2 cycles at start.
- Structure: one enable-gated N-bit register per nonzero entry, a rd_addr decoder, and two 2^ADDR_W:1 read muxes followed by the bypass mux.
- No handshake is needed: writes always complete in one cycle and reads are always valid.

Test Plan:
- Reset then read: hold rst=0 for 2 cycles, release, sweep rs1_addr/rs2_addr 0..31 → all reads 0.
- Basic write/read: write 0xDEADBEEF to x5; next cycle rs1_addr=5, rs2_addr=5 → both 0xDEADBEEF. Entries x4 and x6 still read 0.
- x0 immutability: wr_en=1, rd_addr=0, wr_data=0xFFFFFFFF; same cycle and next cycle rs1_addr=0 → 0x00000000 (no bypass for x0).
- Same-cycle bypass: x7 holds 0x11111111; drive wr_en=1, rd_addr=7, wr_data=0x22222222, rs1_addr=7, rs2_addr=8 in the same cycle.
  - Before the edge: rs1_data=0x22222222, rs2_data=entry[8].
  - After the edge: x7 reads 0x22222222.
- Reset mid-write: x3=0x12345678; at one edge drive rst=0 together with wr_en=1, rd_addr=3, wr_data=0xAAAAAAAA → after the edge x3 reads 0, not 0xAAAAAAAA.
  - While rst=0, rs1_addr=3 with active bypass still reads 0.
- Full sweep: write i*0x01010101 to xi for i=1..31, then read all pairs (i, 31-i) → the expected values, with x0 reading 0.
